branch_update_queue: RTL

Buffers resolved taken branches coming back from the execute stage and replays them, one per cycle, onto the BTB update port (PC_update / target_address_update / update). Sits between branch resolution and the BTB. It holds an update back in any cycle where its PC equals the fetch-side PC_predict, because the BTB ignores updates whose PC matches the prediction PC. It also coalesces repeated resolutions of the same branch so the BTB sees the newest target only once.

---
 rtl/branch_update_queue_pkg.sv | 21 ++
 rtl/branch_update_queue_if.sv | 34 +++
 rtl/branch_update_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/branch_update_queue_pkg.sv
// Shared definitions for the branch update queue: widths, default depth,
// the queue entry layout and the issued-counter helper.
package branch_update_queue_pkg;

    localparam int BQ_PC_W          = 32;
    localparam int BQ_DEFAULT_DEPTH = 4;
    localparam int BQ_CNT_W         = 16;

    // One buffered BTB update: branch PC, resolved target, occupancy flag.
    typedef struct packed {
        logic [BQ_PC_W-1:0] pc;
        logic [BQ_PC_W-1:0] target;
        logic               valid;
    } bq_entry_t;

    // Issued-update counter step; wraps from 16'hffff back to 16'h0000.
    function automatic logic [BQ_CNT_W-1:0] bq_cnt_inc(input logic [BQ_CNT_W-1:0] cnt);
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Bundle of the resolve-side handshake and the BTB update port.
// master = execute stage / fetch / BTB environment, slave = the queue.
interface branch_update_queue_if
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH = BQ_DEFAULT_DEPTH,
    parameter int PC_W  = BQ_PC_W
);

    logic                     resolve_valid;
    logic                     resolve_taken;
    logic [PC_W-1:0]          resolve_pc;
    logic [PC_W-1:0]          resolve_target;
    logic                     resolve_ready;
    logic [PC_W-1:0]          PC_predict;
    logic                     update;
    logic [PC_W-1:0]          PC_update;
    logic [PC_W-1:0]          target_address_update;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [BQ_CNT_W-1:0]      issued_count;

    modport master (
        output resolve_valid, resolve_taken, resolve_pc, resolve_target, PC_predict,
        input  resolve_ready, update, PC_update, target_address_update,
               occupancy, issued_count
    );

    modport slave (
        input  resolve_valid, resolve_taken, resolve_pc, resolve_target, PC_predict,
        output resolve_ready, update, PC_update, target_address_update,
               occupancy, issued_count
    );

endinterface

// File: rtl/branch_update_queue.sv
// Branch update queue: buffers resolved taken branches and replays them one
// per cycle onto the BTB update port. The head is held while its PC equals
// the fetch-side PC_predict (the BTB would ignore that update), and repeated
// resolutions of a still-queued branch overwrite its target in place.
// The PC width follows the package, so the attached interface must use
// PC_W = BQ_PC_W and the same DEPTH as this module.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH = BQ_DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  start,
    branch_update_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    bq_entry_t              r_entries [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [OCC_W-1:0]       r_occ;
    logic [BQ_CNT_W-1:0]    r_issued;

    bq_entry_t              w_head;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_coalesce;
    logic [DEPTH-1:0]       w_match;
    logic [PTR_W-1:0]       w_match_idx;
    logic [OCC_W-1:0]       w_occ_next;

    // Full/empty come from the occupancy count, never from pointer equality.
    assign w_head  = r_entries[r_head];
    assign w_empty = (r_occ == {OCC_W{1'b0}});
    assign w_full  = (r_occ == OCC_FULL);

    // The head issues whenever it exists and does not collide with PC_predict;
    // nothing issues in a reset cycle.
    assign w_pop    = !start && !w_empty && (w_head.pc != bus.PC_predict);
    assign w_accept = bus.resolve_valid && !w_full && bus.resolve_taken;

    // Match vector over live entries; the departing head is excluded so a
    // resolution of the branch being issued becomes a fresh tail entry.
    always_comb begin
        w_match = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entries[i].valid && (r_entries[i].pc == bus.resolve_pc) &&
                !(w_pop && (PTR_W'(i) == r_head))) begin
                w_match[i] = 1'b1;
            end else begin
                w_match[i] = 1'b0;
            end
        end
    end

    // Priority encoder: the lowest matching index wins.
    always_comb begin
        w_match_idx = {PTR_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_match_idx = PTR_W'(i);
            end else begin
                w_match_idx = w_match_idx;
            end
        end
    end

    assign w_coalesce = w_accept && (|w_match);
    assign w_push     = w_accept && !(|w_match);
    assign w_occ_next = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);

    // The BTB consumes these in the same cycle, so they are not re-registered.
    assign bus.resolve_ready         = !w_full;
    assign bus.update                = w_pop;
    assign bus.PC_update             = w_head.pc;
    assign bus.target_address_update = w_head.target;
    assign bus.occupancy             = r_occ;
    assign bus.issued_count          = r_issued;

    // Queue state: pop at head, coalesce in place or push at tail, count issues.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '{pc: {BQ_PC_W{1'b0}}, target: {BQ_PC_W{1'b0}}, valid: 1'b0};
            end
            r_head   <= {PTR_W{1'b0}};
            r_tail   <= {PTR_W{1'b0}};
            r_occ    <= {OCC_W{1'b0}};
            r_issued <= {BQ_CNT_W{1'b0}};
        end else begin
            // Pop and push never share a slot: tail==head with entries means full.
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_ONE;
            end
            if (w_coalesce) begin
                r_entries[w_match_idx].target <= bus.resolve_target;
            end
            if (w_push) begin
                r_entries[r_tail] <= '{pc: bus.resolve_pc, target: bus.resolve_target, valid: 1'b1};
                r_tail            <= r_tail + PTR_ONE;
            end
            r_occ    <= w_occ_next;
            r_issued <= w_pop ? bq_cnt_inc(r_issued) : r_issued;
        end
    end

endmodule
